// File: rtl/reg_file_param.sv
// Parametrised register file: one byte-maskable write port and two combinational read ports.
// Reset is asynchronous. Register 0 can be hardwired to zero and same-cycle write-to-read bypass is optional.
module reg_file_param #(
   parameter int DATA_W   = 32,
   parameter int ADDR_W   = 5,
   parameter int ZERO_REG = 1,
   parameter int BYPASS   = 1
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic [ADDR_W-1:0]     reg_i,
   input  logic [ADDR_W-1:0]     reg_j,
   input  logic [ADDR_W-1:0]     reg_k,
   input  logic [DATA_W-1:0]     i_data,
   input  logic                  w_enable,
   input  logic [DATA_W/8-1:0]   w_byte_en,
   output logic [DATA_W-1:0]     o_data_j,
   output logic [DATA_W-1:0]     o_data_k
);

   localparam int NB    = DATA_W / 8;
   localparam int DEPTH = 1 << ADDR_W;

   logic [DATA_W-1:0] r_mem [DEPTH];
   logic [DATA_W-1:0] w_cur;
   logic [DATA_W-1:0] w_merged;
   logic              w_wr_ok;
   logic              w_zero_tgt;

   assign w_cur      = r_mem[reg_i];
   assign w_zero_tgt = (ZERO_REG == 1) && (reg_i == {ADDR_W{1'b0}});
   // w_wr_ok also gates bypass, so a discarded write to r0 never leaks onto a read port
   assign w_wr_ok    = w_enable && !rst && (w_byte_en != {NB{1'b0}}) && !w_zero_tgt;

   // byte-merge of incoming data with the currently stored word
   always_comb begin
      w_merged = w_cur;
      for (int b = 0; b < NB; b++) begin
         if (w_byte_en[b]) begin
            w_merged[8*b +: 8] = i_data[8*b +: 8];
         end else begin
            w_merged[8*b +: 8] = w_cur[8*b +: 8];
         end
      end
   end

   // storage: asynchronous clear, masked write on the rising edge
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         for (int n = 0; n < DEPTH; n++) begin
            r_mem[n] <= {DATA_W{1'b0}};
         end
      end else if (w_wr_ok) begin
         r_mem[reg_i] <= w_merged;
      end
   end

   // read port j
   always_comb begin
      if (rst) begin
         o_data_j = {DATA_W{1'b0}};
      end else if ((ZERO_REG == 1) && (reg_j == {ADDR_W{1'b0}})) begin
         o_data_j = {DATA_W{1'b0}};
      end else if ((BYPASS == 1) && w_wr_ok && (reg_j == reg_i)) begin
         o_data_j = w_merged;
      end else begin
         o_data_j = r_mem[reg_j];
      end
   end

   // read port k
   always_comb begin
      if (rst) begin
         o_data_k = {DATA_W{1'b0}};
      end else if ((ZERO_REG == 1) && (reg_k == {ADDR_W{1'b0}})) begin
         o_data_k = {DATA_W{1'b0}};
      end else if ((BYPASS == 1) && w_wr_ok && (reg_k == reg_i)) begin
         o_data_k = w_merged;
      end else begin
         o_data_k = r_mem[reg_k];
      end
   end

endmodule

// File: tb/tb_reg_file_param.sv
// Bench for reg_file_param: two configurations side by side (zero-reg+bypass, plain storage without bypass)
// driven by the same inputs and checked against an array-based reference model.
module tb_reg_file_param;

   logic        clk;
   logic        rst;
   logic [4:0]  reg_i;
   logic [4:0]  reg_j;
   logic [4:0]  reg_k;
   logic [31:0] i_data;
   logic        w_enable;
   logic [3:0]  w_byte_en;
   logic [31:0] a_j, a_k, b_j, b_k;

   logic [31:0] mem_a [32];
   logic [31:0] mem_b [32];
   int          n_assert;
   int          n_fail;

   reg_file_param #(.DATA_W(32), .ADDR_W(5), .ZERO_REG(1), .BYPASS(1)) u_dut_a (
      .clk(clk), .rst(rst), .reg_i(reg_i), .reg_j(reg_j), .reg_k(reg_k),
      .i_data(i_data), .w_enable(w_enable), .w_byte_en(w_byte_en),
      .o_data_j(a_j), .o_data_k(a_k)
   );

   reg_file_param #(.DATA_W(32), .ADDR_W(5), .ZERO_REG(0), .BYPASS(0)) u_dut_b (
      .clk(clk), .rst(rst), .reg_i(reg_i), .reg_j(reg_j), .reg_k(reg_k),
      .i_data(i_data), .w_enable(w_enable), .w_byte_en(w_byte_en),
      .o_data_j(b_j), .o_data_k(b_k)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   function automatic logic [31:0] bit_mask(input logic [3:0] be);
      logic [31:0] m;
      m = 32'h0;
      for (int b = 0; b < 4; b++) if (be[b]) m[8*b +: 8] = 8'hFF;
      return m;
   endfunction

   function automatic logic [31:0] merge(input logic [31:0] old_v);
      logic [31:0] m;
      m = bit_mask(w_byte_en);
      return (old_v & ~m) | (i_data & m);
   endfunction

   function automatic logic write_active();
      return w_enable && !rst && (w_byte_en != 4'h0);
   endfunction

   function automatic logic [31:0] exp_a(input logic [4:0] addr);
      if (rst || addr == 5'd0) return 32'h0;
      if (write_active() && addr == reg_i) return merge(mem_a[addr]);
      return mem_a[addr];
   endfunction

   function automatic logic [31:0] exp_b(input logic [4:0] addr);
      if (rst) return 32'h0;
      return mem_b[addr];
   endfunction

   task automatic model_clear();
      for (int n = 0; n < 32; n++) begin
         mem_a[n] = 32'h0;
         mem_b[n] = 32'h0;
      end
   endtask

   task automatic model_edge();
      if (write_active()) begin
         if (reg_i != 5'd0) mem_a[reg_i] = merge(mem_a[reg_i]);
         mem_b[reg_i] = merge(mem_b[reg_i]);
      end
   endtask

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_assert++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   task automatic check_all(input string tag);
      #1;
      chk({tag, ".a_j"}, a_j, exp_a(reg_j));
      chk({tag, ".a_k"}, a_k, exp_a(reg_k));
      chk({tag, ".b_j"}, b_j, exp_b(reg_j));
      chk({tag, ".b_k"}, b_k, exp_b(reg_k));
   endtask

   // check outputs before the edge, clock, update model, check after the edge
   task automatic cycle(input string tag);
      check_all({tag, ".pre"});
      @(posedge clk);
      model_edge();
      #1;
      check_all({tag, ".post"});
   endtask

   task automatic drive(input logic we, input logic [3:0] be, input logic [4:0] wi,
                        input logic [31:0] d, input logic [4:0] rj, input logic [4:0] rk);
      w_enable = we; w_byte_en = be; reg_i = wi; i_data = d; reg_j = rj; reg_k = rk;
   endtask

   initial begin
      n_assert = 0;
      n_fail   = 0;
      rst = 1'b1;
      drive(1'b0, 4'h0, 5'd0, 32'h0, 5'd3, 5'd7);
      model_clear();
      check_all("reset");
      @(negedge clk);
      rst = 1'b0;
      check_all("after_reset");

      // full word write, then read r1/r2
      drive(1'b1, 4'hF, 5'd2, 32'd781, 5'd1, 5'd2);
      cycle("full_wr");
      drive(1'b0, 4'hF, 5'd2, 32'd781, 5'd1, 5'd2);
      check_all("full_rd");
      chk("full_rd.lit_a_k", a_k, 32'd781);
      chk("full_rd.lit_a_j", a_j, 32'd0);

      // byte mask
      drive(1'b1, 4'hF, 5'd3, 32'hAABB_CCDD, 5'd3, 5'd1);
      cycle("bm_init");
      drive(1'b1, 4'b0101, 5'd3, 32'h1122_3344, 5'd3, 5'd2);
      cycle("bm_wr");
      drive(1'b0, 4'h0, 5'd3, 32'h0, 5'd3, 5'd3);
      check_all("bm_rd");
      chk("bm_rd.lit_a", a_j, 32'hAA22_CC44);
      chk("bm_rd.lit_b", b_k, 32'hAA22_CC44);

      // zero register
      drive(1'b1, 4'hF, 5'd0, 32'hFFFF_FFFF, 5'd0, 5'd0);
      cycle("zero_wr");
      chk("zero.lit_a", a_j, 32'h0);
      chk("zero.lit_b", b_j, 32'hFFFF_FFFF);

      // bypass vs no bypass
      drive(1'b1, 4'hF, 5'd4, 32'h10, 5'd1, 5'd2);
      cycle("byp_init");
      drive(1'b1, 4'hF, 5'd4, 32'h99, 5'd4, 5'd4);
      #1;
      chk("byp.pre_lit_a", a_k, 32'h99);
      chk("byp.pre_lit_b", b_k, 32'h10);
      cycle("byp_wr");
      chk("byp.post_lit_b", b_j, 32'h99);

      // empty byte mask gates the write
      drive(1'b1, 4'h0, 5'd4, 32'hDEAD_BEEF, 5'd4, 5'd0);
      cycle("be_zero");
      chk("be_zero.lit", a_j, 32'h99);

      // asynchronous clear between edges, with a write attempt during reset
      drive(1'b1, 4'hF, 5'd5, 32'h1234_5678, 5'd5, 5'd4);
      cycle("pre_rst_wr");
      drive(1'b1, 4'hF, 5'd6, 32'h55, 5'd5, 5'd6);
      rst = 1'b1;
      model_clear();
      check_all("async_rst");
      chk("async_rst.lit", a_j, 32'h0);
      @(posedge clk);
      model_edge();
      #1;
      check_all("rst_edge");
      rst = 1'b0;
      drive(1'b0, 4'h0, 5'd0, 32'h0, 5'd5, 5'd6);
      check_all("rst_released");
      chk("rst_gated.lit", b_k, 32'h0);

      // randomized traffic
      for (int t = 0; t < 300; t++) begin
         drive(($urandom_range(0, 3) != 0), 4'($urandom_range(0, 15)), 5'($urandom_range(0, 31)),
               32'($urandom), 5'($urandom_range(0, 31)), 5'($urandom_range(0, 31)));
         if ($urandom_range(0, 3) == 0) reg_j = reg_i;
         if ($urandom_range(0, 3) == 0) reg_k = reg_i;
         if ($urandom_range(0, 7) == 0) reg_i = 5'd0;
         cycle("rand");
      end

      $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
      $finish;
   end

endmodule

// File: doc/reg_file_param.md
Name: reg_file_param

Overview:
- Parametrised successor to the CPU register file: one write port, two read ports, width and depth set by parameters.
- Adds four features:
  - asynchronous reset that clears all registers;
  - per-byte write enables;
  - optional hardwired-zero register 0;
  - optional same-cycle write-to-read bypass.
- Sits between the decode stage (read addresses) and the writeback stage (write address/data) of the MIPS datapath.

Parameters:
- DATA_W, 32, register width in bits; must be a multiple of 8.
- ADDR_W, 5, address width; depth = 2**ADDR_W registers.
- ZERO_REG, 1, 1 = register 0 always reads 0 and ignores writes; 0 = register 0 is ordinary storage.
- BYPASS, 1, 1 = a read of the register being written this cycle returns the post-write value; 0 = the read returns the stored (pre-write) value.

Ports:
- clk  input  1  clock; register updates on the rising edge.
- rst  input  1  asynchronous, active-high reset.
- reg_i  input  ADDR_W  write address.
- reg_j  input  ADDR_W  read address, port j.
- reg_k  input  ADDR_W  read address, port k.
- i_data  input  DATA_W  write data.
- w_enable  input  1  write strobe.
- w_byte_en  input  DATA_W/8  per-byte write mask; bit b covers i_data[8b+7:8b].
- o_data_j  output  DATA_W  read data, port j.
- o_data_k  output  DATA_W  read data, port k.

Behaviour:
- Reset:
  - rst high clears every register to 0 immediately, without waiting for a clock edge.
  - Both outputs read 0 while rst is high, regardless of addresses or bypass.
  - Writes are blocked while rst is high.
  - Releasing rst mid-cycle takes effect at the next rising edge; an edge coincident with rst high performs no write.
- Write:
  - Occurs on posedge clk when w_enable=1, rst=0 and w_byte_en is non-zero.
  - Only bytes with w_byte_en[b]=1 update; the other bytes of register reg_i keep their value.
  - w_enable=0 or w_byte_en=0 means no state change.
  - With ZERO_REG=1, a write to register 0 is discarded.
- Read:
  - Combinational, zero-cycle latency; o_data_j = reg[reg_j] and o_data_k = reg[reg_k].
  - With ZERO_REG=1, address 0 returns 0 on either port.
- Bypass (BYPASS=1):
  - Applies when w_enable=1, w_byte_en≠0 and reg_i==reg_j (or reg_k).
  - The output shows the byte-merged value: i_data bytes where w_byte_en=1, stored bytes elsewhere.
  - Suppressed for reg_i=0 when ZERO_REG=1; port j and port k are evaluated independently.
- No-bypass (BYPASS=0): outputs show the stored value until the edge, then the new value after it.
- Simultaneous cases:
  - reg_j==reg_k: both ports return the identical value.
  - Write and read of different registers: no interaction.
- Address range: every value in 0..2**ADDR_W-1 is valid; there is no out-of-range case.
- Storage holds no X after reset: all registers are defined as 0.

Test Plan:
- Reset clear: write 32'h1234_5678 to r5, pulse rst for 10 ns between clock edges -> o_data_j (reg_j=5) reads 0 immediately, before any edge.
- Full write: w_enable=1, w_byte_en=4'hF, reg_i=2, i_data=781, edge, then w_enable=0, reg_j=1, reg_k=2 -> o_data_j=0, o_data_k=781.
- Byte mask: r3=32'hAABB_CCDD, write i_data=32'h1122_3344 with w_byte_en=4'b0101 -> r3 reads 32'hAA22_CC44.
- Zero register: ZERO_REG=1, write 32'hFFFF_FFFF to r0 with reg_j=0 during and after the edge -> o_data_j stays 0; with ZERO_REG=0 the same sequence reads 32'hFFFF_FFFF after the edge.
- Bypass: BYPASS=1, r4=0x10, w_enable=1, reg_i=4, i_data=0x99, w_byte_en=4'hF, reg_j=reg_k=4, before the edge -> both ports 0x99; BYPASS=0 -> both ports 0x10 before the edge, 0x99 after.
- Write gating: w_enable=1 with w_byte_en=0, and w_enable=1 with rst high at the edge -> target register unchanged.
